tone_player: RTL and testbench

//  Note-playback engine; the sink for the button-number/note stream feeding the badge speaker.

---
 rtl/tone_player_if.sv | 21 ++
 rtl/tone_player.sv | 180 ++++++++++++++++++
 tb/tb_tone_player.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_player_if.sv
// Note-request channel between the sequencer and the tone player.
// The master offers a request; the slave raises note_ready when it can take it.
interface tone_player_if #(
    parameter int DUR_W = 12
);
    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note;
    logic [1:0]       octave;
    logic [DUR_W-1:0] dur_ms;

    modport master (
        output note_valid, note, octave, dur_ms,
        input  note_ready
    );

    modport slave (
        input  note_valid, note, octave, dur_ms,
        output note_ready
    );
endinterface

// File: rtl/tone_player.sv
// Note-playback engine: plays one chromatic note as a square wave for dur_ms,
// then holds a silent articulation gap before accepting the next request.
module tone_player #(
    parameter int TICK_DIV = 8000,
    parameter int DUR_W    = 12,
    parameter int GAP_MS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_player_if.slave   req,
    input  logic           stop,
    output logic           audio,
    output logic           busy,
    output logic           done
);
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HALF_W = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               audio_q, audio_d;
    logic               done_q, done_d;
    logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   ms_q, ms_d;
    logic [3:0]         note_q, note_d;
    logic [1:0]         octave_q, octave_d;

    logic [HALF_W-1:0]  accept_half;
    logic [HALF_W-1:0]  play_half;
    logic               accept_rest;
    logic               play_rest;

    // Half period in clk cycles; indices 12..15 are rests and yield 0.
    function automatic logic [HALF_W-1:0] half_of(input logic [3:0] n, input logic [1:0] o);
        logic [HALF_W-1:0] per;
        per = '0;
        case (n)
            4'd0:    per = 14'd15289;
            4'd1:    per = 14'd14431;
            4'd2:    per = 14'd13621;
            4'd3:    per = 14'd12856;
            4'd4:    per = 14'd12135;
            4'd5:    per = 14'd11454;
            4'd6:    per = 14'd10811;
            4'd7:    per = 14'd10204;
            4'd8:    per = 14'd9631;
            4'd9:    per = 14'd9091;
            4'd10:   per = 14'd8581;
            4'd11:   per = 14'd8099;
            default: per = '0;
        endcase
        return (per >> o) >> 1;
    endfunction

    assign accept_half = half_of(req.note, req.octave);
    assign play_half   = half_of(note_q, octave_q);
    assign accept_rest = (req.note >= 4'd12);
    assign play_rest   = (note_q >= 4'd12);

    assign req.note_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign audio          = audio_q;
    assign done           = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            audio_q    <= 1'b0;
            done_q     <= 1'b0;
            half_cnt_q <= '0;
            pre_q      <= '0;
            ms_q       <= '0;
            note_q     <= '0;
            octave_q   <= '0;
        end else begin
            state_q    <= state_d;
            audio_q    <= audio_d;
            done_q     <= done_d;
            half_cnt_q <= half_cnt_d;
            pre_q      <= pre_d;
            ms_q       <= ms_d;
            note_q     <= note_d;
            octave_q   <= octave_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        audio_d    = audio_q;
        done_d     = 1'b0;
        half_cnt_d = half_cnt_q;
        pre_d      = pre_q;
        ms_d       = ms_q;
        note_d     = note_q;
        octave_d   = octave_q;

        unique case (state_q)
            IDLE: begin
                // stop is deliberately not looked at here: an accept always wins.
                if (req.note_valid) begin
                    note_d   = req.note;
                    octave_d = req.octave;
                    if (req.dur_ms == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = PLAY;
                        audio_d    = !accept_rest;
                        half_cnt_d = accept_rest ? '0 : accept_half - 1'b1;
                        pre_d      = PRE_W'(TICK_DIV - 1);
                        ms_d       = req.dur_ms;
                    end
                end
            end

            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    audio_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    if (!play_rest) begin
                        if (half_cnt_q == '0) begin
                            audio_d    = !audio_q;
                            half_cnt_d = play_half - 1'b1;
                        end else begin
                            half_cnt_d = half_cnt_q - 1'b1;
                        end
                    end
                    if (pre_q == '0) begin
                        pre_d = PRE_W'(TICK_DIV - 1);
                        if (ms_q == DUR_W'(1)) begin
                            // Last PLAY cycle: silence overrides any pending toggle.
                            audio_d = 1'b0;
                            if (GAP_MS == 0) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = GAP;
                                ms_d    = DUR_W'(GAP_MS);
                            end
                        end else begin
                            ms_d = ms_q - 1'b1;
                        end
                    end else begin
                        pre_d = pre_q - 1'b1;
                    end
                end
            end

            GAP: begin
                audio_d = 1'b0;
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (pre_q == '0) begin
                    pre_d = PRE_W'(TICK_DIV - 1);
                    if (ms_q == DUR_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ms_d = ms_q - 1'b1;
                    end
                end else begin
                    pre_d = pre_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                audio_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player: stimulus pushes expected audio edges and done pulses
// into a scoreboard queue; a monitor pops and compares as the DUT produces them.
module tb_tone_player;
    localparam int TD  = 8000;
    localparam int GAP = 1;

    typedef struct {
        int kind;   // 0 = audio edge, 1 = done pulse
        int cyc;
        int val;
    } ev_t;

    logic clk;
    logic rst_n;
    logic stop;
    logic audio;
    logic busy;
    logic done;

    int   cyc;
    int   checks;
    int   errors;
    int   last_done;
    int   last_busy_len;
    ev_t  sb[$];
    int   per_tab[12] = '{15289, 14431, 13621, 12856, 12135, 11454,
                          10811, 10204, 9631, 9091, 8581, 8099};

    tone_player_if #(.DUR_W(12)) bus ();

    tone_player u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.slave),
        .stop  (stop),
        .audio (audio),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Expected events for a note accepted at posedge k; stop_off > 0 means stop is
    // sampled at posedge k+stop_off; with_done = 0 models a reset at that point.
    function automatic void push_note(input int k, input int n, input int o, input int d,
                                      input int stop_off, input bit with_done);
        int half;
        int play_end;
        int done_c;
        int lvl;
        int prev;
        if (d == 0) begin
            push_ev(1, k, 1);
            last_done = k;
            return;
        end
        half     = (n < 12) ? ((per_tab[n] >> o) >> 1) : 0;
        play_end = k + d * TD;
        done_c   = play_end + GAP * TD;
        if (stop_off > 0) begin
            if (k + stop_off < play_end) play_end = k + stop_off;
            done_c = k + stop_off;
        end
        prev = 0;
        for (int c = k; c < play_end; c++) begin
            lvl = (half == 0) ? 0 : ((((c - k) / half) % 2 == 0) ? 1 : 0);
            if (lvl != prev) push_ev(0, c, lvl);
            prev = lvl;
        end
        if (prev != 0) push_ev(0, play_end, 0);
        if (with_done) push_ev(1, done_c, 1);
        last_done = done_c;
    endfunction

    function automatic void sb_check(input int kind, input int v);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s at cycle %0d value %0d, nothing expected",
                     (kind == 0) ? "edge" : "done", cyc, v);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.val != v) begin
            errors++;
            $display("FAIL event: got %s cyc %0d val %0d, expected %s cyc %0d val %0d",
                     (kind == 0) ? "edge" : "done", cyc, v,
                     (e.kind == 0) ? "edge" : "done", e.cyc, e.val);
        end
    endfunction

    // Monitor: watches audio edges, done pulses and busy run lengths on the falling edge.
    initial begin
        int prev_audio;
        int prev_busy;
        int run;
        prev_audio = 0;
        prev_busy  = 0;
        run        = 0;
        forever begin
            @(negedge clk);
            if (int'(audio) != prev_audio) sb_check(0, int'(audio));
            prev_audio = int'(audio);
            if (done) sb_check(1, 1);
            if (busy) run++;
            else if (prev_busy == 1) begin
                last_busy_len = run;
                run = 0;
            end
            prev_busy = int'(busy);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_pending", sb.size(), 0);
    endtask

    // Called on a falling edge; holds the request until note_ready, returns accept cycle.
    task automatic send(input int n, input int o, input int d, input bit with_stop,
                        input int stop_off, input bit with_done, output int k);
        int waited;
        waited         = 0;
        bus.note       = 4'(n);
        bus.octave     = 2'(o);
        bus.dur_ms     = 12'(d);
        bus.note_valid = 1'b1;
        if (with_stop) stop = 1'b1;
        while (!bus.note_ready && waited < 50000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.note_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: note_ready still %0d after %0d cycles, expected 1",
                     bus.note_ready, waited);
        end
        k = cyc + 1;
        push_note(k, n, o, d, stop_off, with_done);
        $display("NOTE %0d oct %0d dur %0d issued, accept expected at cycle %0d", n, o, d, k);
        @(negedge clk);
        bus.note_valid = 1'b0;
        stop           = 1'b0;
    endtask

    initial begin
        int k;
        int k2;
        int exp_k;
        cyc            = 0;
        checks         = 0;
        errors         = 0;
        last_done      = 0;
        last_busy_len  = 0;
        rst_n          = 1'b0;
        stop           = 1'b0;
        bus.note_valid = 1'b0;
        bus.note       = '0;
        bus.octave     = '0;
        bus.dur_ms     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_audio", int'(audio), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(bus.note_ready), 1);

        // A4 octave 0, 1 ms: half 4545, 8000 cycles PLAY + 8000 GAP
        send(9, 0, 1, 1'b0, 0, 1'b1, k);
        wait_drain(20000);
        chk("busy_len_a4", last_busy_len, 16000);

        // B octave 3, 2 ms: half 506; stop 10 cycles into the gap
        send(11, 3, 2, 1'b0, 16010, 1'b1, k);
        wait_cyc(k + 16009);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain(100);
        chk("busy_len_gap_stop", last_busy_len, 16010);

        // Rest 3 ms, then C octave 2 held while busy, accepted in the done cycle
        send(15, 0, 3, 1'b0, 0, 1'b1, k);
        exp_k = last_done + 1;
        send(0, 2, 1, 1'b0, 4000, 1'b1, k2);
        chk("accept_on_done", k2, exp_k);
        wait_cyc(k2 + 3999);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain(100);

        // Stop alongside accept is ignored; stop 100 cycles into PLAY ends the note
        send(0, 0, 1, 1'b1, 100, 1'b1, k);
        wait_cyc(k + 99);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain(100);
        chk("busy_len_play_stop", last_busy_len, 100);

        // Stop while idle: nothing happens
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_stop_busy", int'(busy), 0);
        chk("idle_stop_ready", int'(bus.note_ready), 1);

        // Zero duration: done next cycle, audio never rises
        send(5, 0, 0, 1'b0, 0, 1'b1, k);
        wait_drain(20);

        // Reset 1000 cycles into a note: audio drops, no done
        send(7, 1, 2, 1'b0, 1000, 1'b0, k);
        wait_cyc(k + 999);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_audio", int'(audio), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(bus.note_ready), 1);
        repeat (20) @(negedge clk);
        chk("final_pending", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
